// File: rtl/viol_reset_seq_if.sv
// Kill-request / reset-status bundle between the security monitors, the core
// and the violation reset sequencer.
interface viol_reset_seq_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] viol_req;
  logic [15:0]        pc;
  logic               cause_clr;
  logic               sys_rst;
  logic               running;
  logic [NUM_SRC-1:0] cause;
  logic [7:0]         viol_count;

  modport master (
    output viol_req, pc, cause_clr,
    input  sys_rst, running, cause, viol_count
  );

  modport slave (
    input  viol_req, pc, cause_clr,
    output sys_rst, running, cause, viol_count
  );
endinterface

// File: rtl/viol_reset_seq.sv
// Turns monitor kill requests into one stretched core reset, records the cause
// and count of violations, and confirms the core restarts at its reset handler.
//
// state   | meaning
// HOLD    | core held in reset; stretch counter running
// WAIT_PC | reset released; waiting for pc to reach the handler
// RUN     | core confirmed running normally
module viol_reset_seq #(
  parameter int          NUM_SRC       = 4,
  parameter int          HOLD_CYCLES   = 16,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          PC_TIMEOUT    = 8
) (
  input logic             clk,
  input logic             reset,
  viol_reset_seq_if.slave bus
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TW = (PC_TIMEOUT > 1) ? $clog2(PC_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(PC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    WAIT_PC = 2'b01,
    RUN     = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [HW-1:0]      hold_cnt, hold_cnt_nxt;
  logic [TW-1:0]      to_cnt, to_cnt_nxt;
  logic [NUM_SRC-1:0] cause_q, cause_nxt;
  logic [7:0]         count_q, count_nxt;
  logic [7:0]         count_inc;
  logic               sys_rst_q, running_q;
  logic               any_viol;

  assign any_viol  = |bus.viol_req;
  assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    to_cnt_nxt   = to_cnt;
    // Any asserted request is sticky in every state; RUN may clear it below.
    cause_nxt    = cause_q | bus.viol_req;
    count_nxt    = count_q;

    case (state)
      RUN: begin
        if (any_viol) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
          count_nxt    = count_inc;
        end else if (bus.cause_clr) begin
          cause_nxt = '0;
        end
      end

      HOLD: begin
        if (hold_cnt != HOLD_LAST) begin
          hold_cnt_nxt = hold_cnt + HW'(1);
        end
        if ((hold_cnt == HOLD_LAST) && !any_viol) begin
          state_nxt  = WAIT_PC;
          to_cnt_nxt = '0;
        end
      end

      WAIT_PC: begin
        if (any_viol) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
          count_nxt    = count_inc;
        end else if (bus.pc == RESET_HANDLER) begin
          state_nxt = RUN;
        end else if (to_cnt == TO_LAST) begin
          // Core never reached its handler: treat as a violation of its own.
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
          count_nxt    = count_inc;
        end else begin
          to_cnt_nxt = to_cnt + TW'(1);
        end
      end

      default: begin
        state_nxt    = HOLD;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      cause_q   <= '0;
      count_q   <= '0;
      sys_rst_q <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      cause_q   <= cause_nxt;
      count_q   <= count_nxt;
      sys_rst_q <= (state_nxt == HOLD);
      running_q <= (state_nxt == RUN);
    end
  end

  assign bus.sys_rst    = sys_rst_q;
  assign bus.running    = running_q;
  assign bus.cause      = cause_q;
  assign bus.viol_count = count_q;

endmodule

// File: tb/tb_viol_reset_seq.sv
// Scenario bench for viol_reset_seq: expectations are queued as stimulus is
// applied and popped against the DUT outputs when they are observed.
module tb_viol_reset_seq;

  localparam logic [15:0] BAD_PC = 16'hE010;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  viol_reset_seq_if #(.NUM_SRC(4)) bus ();

  viol_reset_seq #(
    .NUM_SRC(4),
    .HOLD_CYCLES(16),
    .RESET_HANDLER(16'h0000),
    .PC_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_count = 0;
  int   exp_cause = 0;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk_val("scoreboard_underflow", obs, -1);
    end else begin
      e = sb.pop_front();
      chk_val(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles (including the current one) for which sys_rst stays high.
  task automatic count_high(output int n);
    n = 0;
    while (bus.sys_rst === 1'b1 && n < 300) begin
      n++;
      tick();
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (bus.sys_rst === 1'b0 && n < 300) begin
      n++;
      tick();
    end
  endtask

  // Called in the first WAIT_PC cycle: core reaches handler, running follows.
  task automatic release_to_run(input string tag);
    sb_push({tag, "_run_before"}, 0);
    sb_check(int'(bus.running));
    bus.pc = 16'h0000;
    tick();
    bus.pc = BAD_PC;
    sb_push({tag, "_run_after"}, 1);
    sb_check(int'(bus.running));
  endtask

  task automatic check_status(input string tag);
    sb_push({tag, "_cause"}, exp_cause);
    sb_check(int'(bus.cause));
    sb_push({tag, "_count"}, exp_count);
    sb_check(int'(bus.viol_count));
  endtask

  // Single-cycle violation from RUN, full stretch, then release.
  task automatic pulse_viol(input string tag, input logic [3:0] v);
    int n;
    bus.viol_req = v;
    tick();
    bus.viol_req = '0;
    exp_cause = exp_cause | int'(v);
    exp_count = exp_count + 1;
    sb_push({tag, "_latency"}, 1);
    sb_check(int'(bus.sys_rst));
    count_high(n);
    sb_push({tag, "_hold_len"}, 16);
    sb_check(n);
    check_status(tag);
    release_to_run(tag);
  endtask

  initial begin
    int n, m, k;
    reset         = 1'b1;
    bus.viol_req  = '0;
    bus.pc        = BAD_PC;
    bus.cause_clr = 1'b0;

    // Power-on
    repeat (3) tick();
    sb_push("por_sys_rst", 1);
    sb_check(int'(bus.sys_rst));
    sb_push("por_running", 0);
    sb_check(int'(bus.running));
    check_status("por");
    reset = 1'b0;
    count_high(n);
    sb_push("por_hold_len", 16);
    sb_check(n);
    release_to_run("por");
    check_status("por_end");

    // Single-cycle violation
    pulse_viol("pulse", 4'b0010);

    // Clear alone in RUN
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    exp_cause = 0;
    check_status("clr_alone");

    // Violation held 40 cycles with a second source pulsed in the middle
    n = 0;
    for (int i = 0; i < 40; i++) begin
      bus.viol_req = (i == 20) ? 4'b0101 : 4'b0001;
      tick();
      if (bus.sys_rst === 1'b1) n++;
    end
    bus.viol_req = '0;
    tick();
    count_high(m);
    n += m;
    exp_cause = 5;
    exp_count = exp_count + 1;
    sb_push("held_len", 40);
    sb_check(n);
    check_status("held");

    // pc never reaches the handler: timeout re-enters HOLD
    count_low(n);
    sb_push("timeout_wait_len", 8);
    sb_check(n);
    exp_count = exp_count + 1;
    check_status("timeout");
    count_high(n);
    sb_push("timeout_hold_len", 16);
    sb_check(n);
    release_to_run("timeout");

    // Clear vs violation in the same cycle
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    exp_cause = 0;
    check_status("clr_pre");
    pulse_viol("src3", 4'b1000);
    bus.cause_clr = 1'b1;
    bus.viol_req  = 4'b0001;
    tick();
    bus.cause_clr = 1'b0;
    bus.viol_req  = '0;
    exp_cause = 9;
    exp_count = exp_count + 1;
    sb_push("conflict_sys_rst", 1);
    sb_check(int'(bus.sys_rst));
    check_status("conflict");
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    check_status("clr_in_hold");
    count_high(n);
    sb_push("conflict_hold_rest", 15);
    sb_check(n);
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    check_status("clr_in_wait");
    release_to_run("conflict");
    bus.cause_clr = 1'b1;
    tick();
    bus.cause_clr = 1'b0;
    exp_cause = 0;
    check_status("clr_after");

    // Saturation of the violation counter
    for (int i = 0; i < 260; i++) begin
      k = 0;
      while (bus.sys_rst === 1'b1 && k < 100) begin
        k++;
        tick();
      end
      bus.viol_req = 4'b0001;
      tick();
      bus.viol_req = '0;
    end
    exp_count = (exp_count + 260 > 255) ? 255 : exp_count + 260;
    exp_cause = 1;
    check_status("saturate");

    // Async reset between clock edges, mid-HOLD
    repeat (5) tick();
    #3;
    reset = 1'b1;
    #1;
    sb_push("async_hold_sys_rst", 1);
    sb_check(int'(bus.sys_rst));
    sb_push("async_hold_running", 0);
    sb_check(int'(bus.running));
    exp_cause = 0;
    exp_count = 0;
    check_status("async_hold");
    tick();
    reset = 1'b0;
    count_high(n);
    sb_push("async_rehold_len", 16);
    sb_check(n);

    // Async reset mid-WAIT_PC: sys_rst must rise without a clock edge
    sb_push("wait_sys_rst_low", 0);
    sb_check(int'(bus.sys_rst));
    #3;
    reset = 1'b1;
    #1;
    sb_push("async_wait_sys_rst", 1);
    sb_check(int'(bus.sys_rst));
    tick();
    reset = 1'b0;

    if (sb.size() != 0) chk_val("scoreboard_leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
